// File: rtl/serial_pkg.sv
// Shared definitions for the bit-serial word path (feeder and downstream deserialiser).
package serial_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Bit-counter width for a word of w bits; never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_word_feeder.sv
// Double-buffered parallel-to-serial feeder: LSB-first bit stream with per-word
// first/last framing and a word_done pulse after each word's last bit.
module serial_word_feeder
  import serial_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             t_clk,
  input  logic             r,
  input  logic [WIDTH-1:0] par_data,
  input  logic             par_valid,
  output logic             par_ready,
  output logic             ser_bit,
  output logic             ser_valid,
  output logic             ser_first,
  output logic             ser_last,
  output logic             word_done
);

  localparam int             CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             word_done_d;
  logic             xfer;
  logic             at_last;

  assign par_ready = ~hold_full_q;
  assign xfer      = par_valid & par_ready;
  assign at_last   = (cnt_q == LAST);

  // NOTE: every combinational output and next-state value gets a default
  // before the case, so no path leaves a signal unassigned and no latch forms.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    cnt_d       = cnt_q;
    word_done_d = 1'b0;
    ser_bit     = 1'b0;
    ser_valid   = 1'b0;
    ser_first   = 1'b0;
    ser_last    = 1'b0;

    case (state_q)
      IDLE: begin
        if (xfer) begin
          shreg_d = par_data;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        ser_bit   = shreg_q[0];
        ser_valid = 1'b1;
        ser_first = (cnt_q == '0);
        ser_last  = at_last;
        shreg_d   = shreg_q >> 1;
        cnt_d     = cnt_q + CW'(1);

        if (at_last) begin
          // Word boundary: refill from hold first, else straight from the port.
          word_done_d = 1'b1;
          cnt_d       = '0;
          if (hold_full_q) begin
            shreg_d     = hold_q;
            hold_full_d = 1'b0;
          end else if (xfer) begin
            shreg_d = par_data;
          end else begin
            state_d = IDLE;
          end
        end else if (xfer) begin
          hold_d      = par_data;
          hold_full_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of block evaluation order.
  always_ff @(posedge t_clk or negedge r) begin
    if (!r) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      cnt_q       <= '0;
      word_done   <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      cnt_q       <= cnt_d;
      word_done   <= word_done_d;
    end
  end

endmodule

// File: tb/tb_serial_word_feeder.sv
// Scoreboard bench for serial_word_feeder with a serial two's-complement stage
// modelled downstream of ser_bit.
module tb_serial_word_feeder;

  localparam int W = 8;

  logic         t_clk = 1'b0;
  logic         r     = 1'b1;
  logic [W-1:0] par_data  = '0;
  logic         par_valid = 1'b0;
  logic         par_ready;
  logic         ser_bit, ser_valid, ser_first, ser_last, word_done;

  serial_word_feeder #(.WIDTH(W)) dut (
    .t_clk     (t_clk),
    .r         (r),
    .par_data  (par_data),
    .par_valid (par_valid),
    .par_ready (par_ready),
    .ser_bit   (ser_bit),
    .ser_valid (ser_valid),
    .ser_first (ser_first),
    .ser_last  (ser_last),
    .word_done (word_done)
  );

  always #5 t_clk = ~t_clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard state: words accepted and not yet fully emitted, in order.
  logic [W-1:0] exp_q[$];
  int           accepted = 0;
  int           last_run = 0;

  // Monitor: samples on the falling edge, away from the active rising edge.
  initial begin : monitor
    int           cur_n    = 0;
    int           run      = 0;
    logic [W-1:0] cur_word = '0;
    logic [W-1:0] y_word   = '0;
    logic [W-1:0] w, neg;
    logic         seen     = 1'b0;
    logic         y;
    logic         done_exp = 1'b0;
    forever begin
      @(negedge t_clk);
      if (!r) begin
        exp_q.delete();
        cur_n    = 0;
        run      = 0;
        seen     = 1'b0;
        done_exp = 1'b0;
      end else begin
        check("word_done", word_done, done_exp);
        done_exp = 1'b0;
        // Capacity is the shifter plus one holding slot; gaps never occur while work is queued.
        check("par_ready", par_ready, exp_q.size() < 2);
        check("ser_valid", ser_valid, exp_q.size() != 0);
        if (ser_valid) begin
          run++;
          check("ser_first", ser_first, cur_n == 0);
          check("ser_last", ser_last, cur_n == W - 1);
          // Serial negation: copy up to and including the first 1, invert afterwards.
          y    = ser_first ? ser_bit : (ser_bit ^ seen);
          seen = ser_first ? ser_bit : (seen | ser_bit);
          cur_word[cur_n] = ser_bit;
          y_word[cur_n]   = y;
          cur_n++;
          if (cur_n == W) begin
            if (exp_q.size() == 0) begin
              check("unexpected_word", 1, 0);
            end else begin
              w   = exp_q.pop_front();
              neg = -w;
              check("data", cur_word, w);
              check("twos_comp", y_word, neg);
            end
            cur_n    = 0;
            done_exp = 1'b1;
          end
        end else begin
          if (run != 0) last_run = run;
          run = 0;
          check("idle_outputs", {ser_bit, ser_first, ser_last}, 0);
        end
        if (par_valid && par_ready) begin
          exp_q.push_back(par_data);
          accepted++;
        end
      end
    end
  end

  task automatic send_word(input logic [W-1:0] w, input bit keep);
    int n = 0;
    par_data  = w;
    par_valid = 1'b1;
    forever begin
      @(negedge t_clk);
      if (par_ready) break;
      n++;
      if (n > 200) begin
        check("send_timeout", 1, 0);
        break;
      end
    end
    @(posedge t_clk);
    #1;
    if (!keep) par_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    forever begin
      @(negedge t_clk);
      if (exp_q.size() == 0 && !ser_valid) break;
      n++;
      if (n > 400) begin
        check("idle_timeout", 1, 0);
        break;
      end
    end
    repeat (2) @(posedge t_clk);
    #1;
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int a0, a1;
    #1 r = 1'b0;
    #1;
    check("reset_outputs", {ser_bit, ser_valid, ser_first, ser_last, word_done}, 0);
    repeat (2) @(posedge t_clk);
    #2 r = 1'b1;
    @(posedge t_clk);
    #1;
    check("ready_after_reset", par_ready, 1);

    // Single word, then return to idle.
    send_word(8'hB4, 1'b0);
    wait_idle();
    check("single_run", last_run, W);

    // Back-to-back stream with par_valid held high.
    send_word(8'h01, 1'b1);
    send_word(8'hFF, 1'b1);
    send_word(8'h80, 1'b0);
    wait_idle();
    check("b2b_run", last_run, 3 * W);

    // Chained negation corner cases.
    send_word(8'h00, 1'b0);
    wait_idle();
    send_word(8'h80, 1'b0);
    wait_idle();
    send_word(8'h01, 1'b1);
    send_word(8'h01, 1'b0);
    wait_idle();
    check("b2b_ones_run", last_run, 2 * W);

    // Saturating source: steady state accepts exactly one word per W cycles.
    par_valid = 1'b1;
    a0 = 0;
    a1 = 0;
    for (int i = 0; i <= 80; i++) begin
      par_data = W'($urandom);
      if (i == 16) a0 = accepted;
      if (i == 80) a1 = accepted;
      @(posedge t_clk);
      #1;
    end
    par_valid = 1'b0;
    check("backpressure_rate", a1 - a0, 64 / W);
    wait_idle();

    // Reset during bit 3 of A5 while 3C sits in the holding register.
    send_word(8'hA5, 1'b0);
    send_word(8'h3C, 1'b0);
    repeat (2) @(posedge t_clk);
    #2 r = 1'b0;
    #1;
    check("midword_reset_outputs", {ser_bit, ser_valid, ser_first, ser_last, word_done}, 0);
    check("midword_reset_ready", par_ready, 1);
    @(negedge t_clk);
    @(posedge t_clk);
    #2 r = 1'b1;
    @(posedge t_clk);
    #1;
    send_word(8'h11, 1'b0);
    wait_idle();

    // Randomised words with random gaps and occasional back-to-back runs.
    for (int i = 0; i < 40; i++) begin
      send_word(W'($urandom), ($urandom_range(0, 2) == 0));
      if (!par_valid) repeat ($urandom_range(0, 10)) @(posedge t_clk);
      #0;
    end
    par_valid = 1'b0;
    wait_idle();
    check("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
